mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle shift-add multiply controller for the single-cycle RISC-V core.
//  It borrows the shared 32-bit ALU (add op 4'b0000) for one addition per iteration.
//  It holds the PC/pipeline with stall_o until the product is ready.
//  Sits beside alucontrol; owns the ALU operand/op mux while alu_grant_o=1.
// PARAMETERS
//  WIDTH      32   operand/result width; iterations per multiply = WIDTH
//  ALU_ADD_OP 4'b0000  ALU operation code driven for partial-product add
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  start_i      in   1        one-cycle request; sampled only in IDLE
//  func3_i      in   3        000 MUL (low word), 001 MULH, 011 MULHU
//  rs1_i        in   WIDTH    multiplicand
//  rs2_i        in   WIDTH    multiplier
//  alu_result_i in   WIDTH    sum returned by shared ALU (combinational)
//  alu_grant_o  out  1        1 = ALU mux selects sequencer operands
//  alu_op_o     out  4        ALU operation while granted
//  alu_a_o      out  WIDTH    ALU operand A (accumulator high half)
//  alu_b_o      out  WIDTH    ALU operand B (multiplicand)
//  stall_o      out  1        freeze PC/regfile write
//  done_o       out  1        one-cycle pulse; result_o valid this cycle only
//  result_o     out  WIDTH    selected product word
// BEHAVIOUR
//  Reset: state=IDLE; acc, mcand, count, sign flag = 0; all outputs 0.
//  FSM: IDLE -> RUN on start_i; RUN -> NEG (signed MULH, result negative) or DONE
//   after count reaches WIDTH-1; NEG -> DONE; DONE -> IDLE unconditionally.
//  IDLE: stall_o = start_i (combinational, so the issuing instruction is held).
//   On start: acc_hi=0, acc_lo=rs2 (|rs2| for MULH), mcand=rs1 (|rs1| for MULH),
//   count=0, neg = rs1[W-1]^rs2[W-1] when MULH; latch func3.
//  RUN (one cycle per multiplier bit): alu_grant_o=1, alu_op_o=ALU_ADD_OP,
//   alu_a_o=acc_hi, alu_b_o=mcand. If acc_lo[0]: sum=alu_result_i,
//   carry=(alu_result_i < acc_hi) unsigned; else sum=acc_hi, carry=0.
//   {acc_hi,acc_lo} <= {carry,sum,acc_lo[W-1:1]}. count increments.
//  NEG: acc <= ~acc + 1 over 2*WIDTH bits (internal adder, ALU not granted).
//  DONE: done_o=1, stall_o=0, alu_grant_o=0; result_o = acc_lo (MUL) or acc_hi.
//  stall_o=1 in RUN and NEG. Latency start->done_o: WIDTH+1 cycles (+1 with NEG).
//  Outside DONE result_o=0; outside RUN alu_op_o/alu_a_o/alu_b_o=0.
//  start_i in RUN/NEG/DONE ignored (no queueing).
//  Unsupported func3 (incl. MULH/MULHU when macro off): ignored as MUL (low word).
//  Zero operand: still full WIDTH iterations; no early exit.
//  Reset asserted mid-operation: immediate return to IDLE, stall_o=0, no done_o.
//  Operand inputs are not required stable after the start cycle.
// CONFIGURATION
//  MUL_SEQ_MULH_EN defined: MULH (signed x signed) and MULHU supported; NEG state
//   present; sign flag register exists.
//  Not defined: only MUL implemented; func3 ignored; no NEG state; latency
//   always WIDTH+1; result_o always low word. (Low word is sign-agnostic.)
// STRUCTURE
//  Shared package riscv_pkg: state encoding (S_IDLE,S_RUN,S_NEG,S_DONE),
//   func3 constants F3_MUL/F3_MULH/F3_MULHU, ALU op code constants.
//  Single module; counter width $clog2(WIDTH). No sub-module needed; the
//   ALU operand mux lives in the datapath top, controlled by alu_grant_o.
// TESTING (bench models ALU as combinational a+b)
//  1 MUL 7*6: start, rs1=7 rs2=6 -> stall_o high 33 cycles, done_o at cycle
//    33 with result_o=42; next cycle IDLE, stall_o=0.
//  2 MUL 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001; MULHU same -> 0xFFFFFFFE
//    (carry path exercised).
//  3 MULH -3*5 -> result_o=0xFFFFFFFF at cycle 34; MULH 0x80000000*0x80000000
//    -> 0x40000000 (macro on only).
//  4 start_i pulsed at cycles 5 and 20 of a running MUL 3*4 -> single done_o,
//    result_o=12, second start ignored.
//  5 reset low at cycle 10 of a run -> outputs 0 immediately, no done_o;
//    new MUL 0*123 after release -> done_o at cycle 33, result_o=0.
//  6 Macro off: func3=001 rs1=2 rs2=3 -> result_o=6, latency 33.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared state, func3 and ALU opcode constants for the multiply sequencer
package riscv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} mul_state_e;
  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULH  = 3'b001;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add multiplier borrowing the shared ALU; MUL_SEQ_MULH_EN adds MULH/MULHU
module mul_sequencer
  import riscv_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] ALU_ADD_OP = ALU_OP_ADD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       func3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             alu_grant_o,
  output logic [3:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  mul_state_e       r_state;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_mcand;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_sum, w_mcand, w_mplier;
  logic             w_carry, w_last, w_neg, w_hi_sel;
`ifdef MUL_SEQ_MULH_EN
  logic       r_neg;
  logic [2:0] r_func3;
  logic       w_mulh;
  assign w_mulh   = func3_i == F3_MULH;
  assign w_mcand  = (w_mulh && rs1_i[WIDTH-1]) ? -rs1_i : rs1_i;
  assign w_mplier = (w_mulh && rs2_i[WIDTH-1]) ? -rs2_i : rs2_i;
  assign w_neg    = r_neg;
  assign w_hi_sel = (r_func3 == F3_MULH) || (r_func3 == F3_MULHU);
`else
  logic w_unused_func3;
  assign w_unused_func3 = ^func3_i;
  assign w_mcand  = rs1_i;
  assign w_mplier = rs2_i;
  assign w_neg    = 1'b0;
  assign w_hi_sel = 1'b0;
`endif
  // the ALU add is 32-bit; an unsigned wrap reveals the carry into bit WIDTH
  assign w_sum   = r_acc_lo[0] ? alu_result_i : r_acc_hi;
  assign w_carry = r_acc_lo[0] && (alu_result_i < r_acc_hi);
  assign w_last  = r_count == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_count  <= '0;
`ifdef MUL_SEQ_MULH_EN
      r_neg    <= 1'b0;
      r_func3  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_state  <= S_RUN;
          r_acc_hi <= '0;
          r_acc_lo <= w_mplier;
          r_mcand  <= w_mcand;
          r_count  <= '0;
`ifdef MUL_SEQ_MULH_EN
          r_neg    <= w_mulh && (rs1_i[WIDTH-1] ^ rs2_i[WIDTH-1]);
          r_func3  <= func3_i;
`endif
        end
        S_RUN: begin
          {r_acc_hi, r_acc_lo} <= {w_carry, w_sum, r_acc_lo[WIDTH-1:1]};
          r_count <= r_count + 1'b1;
          if (w_last) r_state <= w_neg ? S_NEG : S_DONE;
        end
`ifdef MUL_SEQ_MULH_EN
        S_NEG: begin
          {r_acc_hi, r_acc_lo} <= ~{r_acc_hi, r_acc_lo} + (2*WIDTH)'(1);
          r_state <= S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign alu_grant_o = r_state == S_RUN;
  assign alu_op_o    = alu_grant_o ? ALU_ADD_OP : '0;
  assign alu_a_o     = alu_grant_o ? r_acc_hi : '0;
  assign alu_b_o     = alu_grant_o ? r_mcand : '0;
  assign done_o      = r_state == S_DONE;
  assign result_o    = done_o ? (w_hi_sel ? r_acc_hi : r_acc_lo) : '0;
  assign stall_o     = reset && ((r_state == S_IDLE) ? start_i : (r_state != S_DONE));
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: randomized scoreboard bench comparing against a 64-bit arithmetic product model
module tb_mul_sequencer;
  logic        clk = 0, reset = 1, start_i = 0;
  logic [2:0]  func3_i = 0;
  logic [31:0] rs1_i = 0, rs2_i = 0, alu_result_i;
  logic        alu_grant_o, stall_o, done_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, result_o;
  typedef struct {logic [31:0] res; int lat;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, start_cyc = 0;
  mul_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .func3_i(func3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_result_i(alu_result_i),
    .alu_grant_o(alu_grant_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );
  assign alu_result_i = alu_a_o + alu_b_o;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp_v);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] u;
    logic signed [63:0] s;
    u = {32'b0, a} * {32'b0, b};
    s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`ifdef MUL_SEQ_MULH_EN
    if (f3 == 3'b001) return s[63:32];
    if (f3 == 3'b011) return u[63:32];
`endif
    return u[31:0];
  endfunction
  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SEQ_MULH_EN
    if (f3 == 3'b001 && (a[31] ^ b[31])) return 34;
`endif
    return 33;
  endfunction
  always @(negedge clk) if (done_o) begin
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done: got result %0h with nothing outstanding", result_o);
    end else begin
      exp_t e;
      e = sb.pop_front();
      check("result", result_o, e.res);
      check("latency", cyc - start_cyc, e.lat);
      check("done_stall", stall_o, 0);
    end
  end
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int pa, input int pb, input int rst_at, input bit chk_stall);
    exp_t e;
    int sc;
    bit seen;
    e.res = model(f3, a, b);
    e.lat = latency(f3, a, b);
    @(negedge clk);
    func3_i = f3; rs1_i = a; rs2_i = b; start_i = 1; start_cyc = cyc;
    sb.push_back(e);
    #1 sc = int'(stall_o);
    @(negedge clk);
    start_i = 0; rs1_i = $urandom; rs2_i = $urandom; func3_i = 3'($urandom);
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == rst_at) begin
        reset = 0;
        #1;
        check("rst_ctrl", {stall_o, done_o, alu_grant_o}, 0);
        check("rst_bus", |{alu_op_o, alu_a_o, alu_b_o, result_o}, 0);
        e = sb.pop_back();
        @(negedge clk);
        reset = 1;
        for (int j = 0; j < 36; j++) @(negedge clk);
        check("rst_idle", stall_o, 0);
        return;
      end
      if (done_o) begin
        seen = 1;
        break;
      end
      start_i = (k == pa || k == pb);
      sc += int'(stall_o);
      @(negedge clk);
    end
    start_i = 0;
    check("done_seen", seen, 1);
    if (chk_stall) check("stall_cycles", sc, 33);
    @(negedge clk);
    check("idle_stall", stall_o, 0);
    check("sb_drained", sb.size(), 0);
  endtask
  initial begin
    logic [31:0] ops [4];
    logic [2:0]  f3s [5];
    ops[0] = 32'h0; ops[1] = 32'hFFFFFFFF; ops[2] = 32'h80000000; ops[3] = 32'h1;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b011; f3s[3] = 3'b010; f3s[4] = 3'b111;
    #2 reset = 0;
    start_i = 1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {stall_o, done_o, alu_grant_o}, 0);
    check("reset_bus", |{alu_op_o, alu_a_o, alu_b_o, result_o}, 0);
    start_i = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    check("reset_exp_42", model(3'b000, 7, 6), 42);
    run_op(3'b000, 7, 6, 0, 0, 0, 1);
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op(3'b001, 32'hFFFFFFFD, 5, 0, 0, 0, 0);
    run_op(3'b001, 32'h80000000, 32'h80000000, 0, 0, 0, 0);
    run_op(3'b000, 3, 4, 5, 20, 0, 1);
    run_op(3'b000, 9, 9, 0, 0, 10, 0);
    run_op(3'b000, 0, 123, 0, 0, 0, 1);
    run_op(3'b001, 2, 3, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom;
      run_op(f3s[$urandom_range(0, 4)], a, b, 0, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
